fetch_pair_queue: RTL and testbench

//  Dual-issue fetch-side instruction queue: accepts up to two instructions per cycle from
//  the fetch stage and presents the two oldest entries, in program order, to the IF/ID

---
 rtl/fetch_pair_queue.sv | 140 ++++++++++++++
 tb/tb_fetch_pair_queue.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pair_queue.sv
// rtl/fetch_pair_queue.sv - dual-issue fetch-side instruction queue feeding the IF/ID pair
//
// Purpose:
//   Accepts up to two instructions per cycle from fetch and presents the two oldest
//   entries, in program order, to decode. Decode consumes 0, 1 or 2 entries per cycle.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   flush                    discard all entries (redirect / mispredict)
//   push_valid               fetch presents a group this cycle
//   push_b_valid             second instruction of the group is valid
//   push_pc                  PC of first instruction (second is push_pc + 4)
//   push_instr_a/_b          first / second instruction
//   push_ready               at least two free entries
//   consume_0 / consume_1    decode takes slot 0 / slot 1 (slot 1 only with slot 0)
//   out_valid_0/_1           slot 0 / slot 1 holds an entry
//   out_pc_*, out_pcplus4_*, out_instr_*   oldest (0) and second-oldest (1) entries
//   count                    occupied entries

module fetch_pair_queue #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push_valid,
  input  logic                       push_b_valid,
  input  logic [XLEN-1:0]            push_pc,
  input  logic [XLEN-1:0]            push_instr_a,
  input  logic [XLEN-1:0]            push_instr_b,
  output logic                       push_ready,
  input  logic                       consume_0,
  input  logic                       consume_1,
  output logic                       out_valid_0,
  output logic                       out_valid_1,
  output logic [XLEN-1:0]            out_pc_0,
  output logic [XLEN-1:0]            out_pcplus4_0,
  output logic [XLEN-1:0]            out_instr_0,
  output logic [XLEN-1:0]            out_pc_1,
  output logic [XLEN-1:0]            out_pcplus4_1,
  output logic [XLEN-1:0]            out_instr_1,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Full-group threshold: free entries >= 2  <=>  count <= DEPTH - 2.
  localparam logic [CW-1:0] READY_LIMIT = CW'(DEPTH - 2);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] NOP_INSTR  = XLEN'(32'h13);

  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [XLEN-1:0] mem_instr [DEPTH];

  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW-1:0]   head_p1;
  logic [AW-1:0]   tail_p1;

  logic            push_acc;
  logic [CW-1:0]   push_n;
  logic [CW-1:0]   pop_n;
  logic [XLEN-1:0] push_pc_b;

  // Pointers are AW bits wide, so +1 wraps modulo DEPTH for free.
  assign head_p1   = head + AW'(1);
  assign tail_p1   = tail + AW'(1);
  assign push_pc_b = push_pc + PC_STEP;

  // Readiness looks only at the registered count: no credit for same-cycle pops.
  assign push_ready = (count <= READY_LIMIT);
  assign push_acc   = push_valid && push_ready;

  assign out_valid_0 = (count >= CW'(1));
  assign out_valid_1 = (count >= CW'(2));

  always_comb begin
    push_n = '0;
    if (push_acc) begin
      push_n = push_b_valid ? CW'(2) : CW'(1);
    end
  end

  // In-order pops: slot 1 can only go together with slot 0; gating on the valid
  // flags clamps the pop count to the occupancy.
  always_comb begin
    pop_n = '0;
    if (consume_0 && out_valid_0) begin
      pop_n = (consume_1 && out_valid_1) ? CW'(2) : CW'(1);
    end
  end

  // Invalid slots present a NOP at PC 0 so decode never sees stale storage.
  always_comb begin
    out_pc_0    = '0;
    out_instr_0 = NOP_INSTR;
    out_pc_1    = '0;
    out_instr_1 = NOP_INSTR;
    if (out_valid_0) begin
      out_pc_0    = mem_pc[head];
      out_instr_0 = mem_instr[head];
    end
    if (out_valid_1) begin
      out_pc_1    = mem_pc[head_p1];
      out_instr_1 = mem_instr[head_p1];
    end
  end

  assign out_pcplus4_0 = out_pc_0 + PC_STEP;
  assign out_pcplus4_1 = out_pc_1 + PC_STEP;

  // Pointer and occupancy state. Flush behaves exactly like reset and drops any
  // push or consume presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(pop_n);
      tail  <= tail + AW'(push_n);
      count <= count + push_n - pop_n;
    end
  end

  // Storage needs no reset: entries are only observed once counted as valid.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_acc) begin
      mem_pc[tail]    <= push_pc;
      mem_instr[tail] <= push_instr_a;
      if (push_b_valid) begin
        mem_pc[tail_p1]    <= push_pc_b;
        mem_instr[tail_p1] <= push_instr_b;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pair_queue.sv
// tb/tb_fetch_pair_queue.sv - directed self-checking bench for fetch_pair_queue

module tb_fetch_pair_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        push_valid;
  logic        push_b_valid;
  logic [31:0] push_pc;
  logic [31:0] push_instr_a;
  logic [31:0] push_instr_b;
  logic        push_ready;
  logic        consume_0;
  logic        consume_1;
  logic        out_valid_0;
  logic        out_valid_1;
  logic [31:0] out_pc_0;
  logic [31:0] out_pcplus4_0;
  logic [31:0] out_instr_0;
  logic [31:0] out_pc_1;
  logic [31:0] out_pcplus4_1;
  logic [31:0] out_instr_1;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  fetch_pair_queue #(.DEPTH(8), .XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .push_valid    (push_valid),
    .push_b_valid  (push_b_valid),
    .push_pc       (push_pc),
    .push_instr_a  (push_instr_a),
    .push_instr_b  (push_instr_b),
    .push_ready    (push_ready),
    .consume_0     (consume_0),
    .consume_1     (consume_1),
    .out_valid_0   (out_valid_0),
    .out_valid_1   (out_valid_1),
    .out_pc_0      (out_pc_0),
    .out_pcplus4_0 (out_pcplus4_0),
    .out_instr_0   (out_instr_0),
    .out_pc_1      (out_pc_1),
    .out_pcplus4_1 (out_pcplus4_1),
    .out_instr_1   (out_instr_1),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush        = 1'b0;
    push_valid   = 1'b0;
    push_b_valid = 1'b0;
    push_pc      = '0;
    push_instr_a = '0;
    push_instr_b = '0;
    consume_0    = 1'b0;
    consume_1    = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic bv);
    push_valid   = 1'b1;
    push_b_valid = bv;
    push_pc      = pc;
    push_instr_a = 32'hA000_0000 | pc;
    push_instr_b = 32'hB000_0000 | pc;
  endtask

  logic [3:0]  ops [0:11];
  logic [31:0] mq [$];
  logic [31:0] next_pc;
  logic [31:0] last_pop;
  logic [31:0] popped;
  int          npop;

  initial begin
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // 1 reset state
    check("rst_count", count, 0);
    check("rst_valid", {out_valid_0, out_valid_1}, 2'b00);
    check("rst_instr0", out_instr_0, 32'h13);
    check("rst_pcplus4_0", out_pcplus4_0, 4);
    check("rst_ready", push_ready, 1);

    // 2 pair push
    push_valid = 1'b1; push_b_valid = 1'b1; push_pc = 32'h100;
    push_instr_a = 32'h00500093; push_instr_b = 32'h00A00113;
    step(); idle();
    check("pair_valid", {out_valid_0, out_valid_1}, 2'b11);
    check("pair_pc0", out_pc_0, 32'h100);
    check("pair_pc1", out_pc_1, 32'h104);
    check("pair_pcplus4_1", out_pcplus4_1, 32'h108);
    check("pair_instr1", out_instr_1, 32'h00A00113);
    check("pair_count", count, 2);

    // 3 fill to full, drop, then drain two
    flush = 1'b1; step(); idle();
    for (int i = 0; i < 4; i++) begin
      push(32'h100 + 32'(i * 8), 1'b1);
      step(); idle();
    end
    check("full_count", count, 8);
    check("full_ready", push_ready, 0);
    push(32'h120, 1'b1);
    step(); idle();
    check("drop_count", count, 8);
    consume_0 = 1'b1; consume_1 = 1'b1;
    step(); idle();
    check("drain_count", count, 6);
    check("drain_ready", push_ready, 1);
    check("drain_pc0", out_pc_0, 32'h108);
    check("drain_instr0", out_instr_0, 32'hA000_0108);

    // 4 wrap / order against a queue model, starting empty
    flush = 1'b1; step(); idle();
    ops = '{4'b1100, 4'b1110, 4'b1111, 4'b1100, 4'b1010, 4'b1111,
            4'b1110, 4'b1100, 4'b1011, 4'b1111, 4'b1010, 4'b0011};
    mq.delete();
    next_pc  = 32'h300;
    last_pop = 32'h2FC;
    for (int i = 0; i < 12; i++) begin
      check("wrap_count", count, mq.size());
      if (mq.size() >= 1) check("wrap_pc0", out_pc_0, mq[0]);
      if (mq.size() >= 2) check("wrap_pc1", out_pc_1, mq[1]);
      push(next_pc, ops[i][2]);
      push_valid = ops[i][3];
      consume_0  = ops[i][1];
      consume_1  = ops[i][0];
      npop = 0;
      if (ops[i][1] && mq.size() >= 1) npop = (ops[i][0] && mq.size() >= 2) ? 2 : 1;
      for (int k = 0; k < npop; k++) begin
        popped = mq.pop_front();
        check("wrap_order", popped, last_pop + 32'd4);
        last_pop = popped;
      end
      if (ops[i][3] && (mq.size() + npop) <= 6) begin
        mq.push_back(next_pc);
        if (ops[i][2]) mq.push_back(next_pc + 32'd4);
        next_pc = next_pc + (ops[i][2] ? 32'd8 : 32'd4);
      end
      step(); idle();
    end
    check("wrap_final_count", count, mq.size());
    check("wrap_final_pc0", out_pc_0, mq[0]);

    // 5 flush beats same-cycle push and consume
    push(32'h900, 1'b1);
    consume_0 = 1'b1;
    flush = 1'b1;
    step(); idle();
    check("flush_count", count, 0);
    check("flush_valid", {out_valid_0, out_valid_1}, 2'b00);
    step();
    check("flush_absent_count", count, 0);
    check("flush_absent_pc0", out_pc_0, 0);

    // 6 single push and in-order consume rule
    push(32'h200, 1'b0);
    step(); idle();
    check("single_count", count, 1);
    check("single_valid1", out_valid_1, 0);
    check("single_instr1_nop", out_instr_1, 32'h13);
    check("single_pcplus4_1", out_pcplus4_1, 4);
    consume_1 = 1'b1;
    step(); idle();
    check("c1_only_count", count, 1);
    check("c1_only_pc0", out_pc_0, 32'h200);
    consume_0 = 1'b1; consume_1 = 1'b1;
    step(); idle();
    check("clamp_count", count, 0);

    // PC wrap modulo 2^32
    push(32'hFFFF_FFFC, 1'b1);
    step(); idle();
    check("pcwrap_pcplus4_0", out_pcplus4_0, 0);
    check("pcwrap_pc1", out_pc_1, 0);
    check("pcwrap_pcplus4_1", out_pcplus4_1, 4);

    // reset clears a non-empty queue
    rst = 1'b1; step(); rst = 1'b0;
    check("rst2_count", count, 0);
    check("rst2_ready", push_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
